// File: rtl/ld_use_stall_ctrl_pkg.sv
// Shared state codes and defaults for the load-use stall / D-cache freeze controller.
// Optional perf counters in the top are enabled by the LD_USE_PERF_CNT_EN macro.
package ld_use_stall_ctrl_pkg;

    localparam int LDU_STATE_WIDTH = 2;

    typedef enum logic [LDU_STATE_WIDTH-1:0] {
        LDU_ST_RUN     = 2'd0,
        LDU_ST_BUBBLE  = 2'd1,
        LDU_ST_MEMWAIT = 2'd2,
        LDU_ST_ILLEGAL = 2'd3
    } ldu_state_e;

    localparam int LDU_TIMEOUT_LIMIT_DEFAULT = 200;

endpackage

// File: rtl/ldu_src_match.sv
// Three-source comparator: flags a decode instruction that reads the rd of a load
// sitting in EX. Register x0 never matches.
module ldu_src_match #(
    parameter int RF_ADDR_WIDTH = 5
) (
    input  logic [RF_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [RF_ADDR_WIDTH-1:0] rs2_addr,
    input  logic [RF_ADDR_WIDTH-1:0] rs3_addr,
    input  logic [2:0]               rs_used,
    input  logic                     id_valid,
    input  logic [RF_ADDR_WIDTH-1:0] rd_addr,
    input  logic                     ld_en,
    input  logic                     ex_valid,
    output logic                     lu_hit
);

    logic [2:0] src_hit;

    always_comb begin
        src_hit[0] = rs_used[0] & (rs1_addr == rd_addr);
        src_hit[1] = rs_used[1] & (rs2_addr == rd_addr);
        src_hit[2] = rs_used[2] & (rs3_addr == rd_addr);
        lu_hit     = id_valid & ex_valid & ld_en & (rd_addr != '0) & (|src_hit);
    end

endmodule

// File: rtl/ld_use_stall_ctrl.sv
// Load-use bubble insertion and D-cache miss freeze with a sticky wait timeout.
// Define LD_USE_PERF_CNT_EN to add the Perf_LuStallCnt / Perf_MemWaitCnt counters.
module ld_use_stall_ctrl
    import ld_use_stall_ctrl_pkg::*;
#(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int TIMEOUT_W     = 8,
    parameter int TIMEOUT_LIMIT = LDU_TIMEOUT_LIMIT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RF_ADDR_WIDTH-1:0]   ID_Rs1Addr,
    input  logic [RF_ADDR_WIDTH-1:0]   ID_Rs2Addr,
    input  logic [RF_ADDR_WIDTH-1:0]   ID_Rs3Addr,
    input  logic [2:0]                 ID_RsUsed,
    input  logic                       ID_Valid,
    input  logic [RF_ADDR_WIDTH-1:0]   IDEX_RdAddr,
    input  logic                       IDEX_LdEN,
    input  logic                       IDEX_Valid,
    input  logic                       Mem_LdEN,
    input  logic                       Dcache_Ready,
    output logic                       Ctrl_PcHold,
    output logic                       Ctrl_IFIDHold,
    output logic                       Ctrl_IDEXFlush,
    output logic                       Ctrl_PipeFreeze,
    output logic                       Ctrl_MemTimeout,
`ifdef LD_USE_PERF_CNT_EN
    output logic [31:0]                Perf_LuStallCnt,
    output logic [31:0]                Perf_MemWaitCnt,
`endif
    output logic [LDU_STATE_WIDTH-1:0] Ctrl_State
);

    ldu_state_e           state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                 timeout_q;
    logic                 lu_hit;
    logic                 miss;
    logic                 pc_hold, ifid_hold, idex_flush, pipe_freeze;

    ldu_src_match #(.RF_ADDR_WIDTH(RF_ADDR_WIDTH)) u_src_match (
        .rs1_addr (ID_Rs1Addr),
        .rs2_addr (ID_Rs2Addr),
        .rs3_addr (ID_Rs3Addr),
        .rs_used  (ID_RsUsed),
        .id_valid (ID_Valid),
        .rd_addr  (IDEX_RdAddr),
        .ld_en    (IDEX_LdEN),
        .ex_valid (IDEX_Valid),
        .lu_hit   (lu_hit)
    );

    assign miss = Mem_LdEN & ~Dcache_Ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LDU_ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d >= TIMEOUT_W'(TIMEOUT_LIMIT))
                timeout_q <= 1'b1;
        end
    end

    // Freeze outranks load-use: a miss in RUN/BUBBLE never also flushes.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        case (state_q)
            LDU_ST_RUN, LDU_ST_BUBBLE: begin
                if (miss) begin
                    pipe_freeze = 1'b1;
                    pc_hold     = 1'b1;
                    state_d     = LDU_ST_MEMWAIT;
                    wait_cnt_d  = TIMEOUT_W'(1);
                end else if (lu_hit) begin
                    pc_hold    = 1'b1;
                    ifid_hold  = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = LDU_ST_BUBBLE;
                end else begin
                    state_d = LDU_ST_RUN;
                end
            end
            LDU_ST_MEMWAIT: begin
                if (!Dcache_Ready) begin
                    pipe_freeze = 1'b1;
                    pc_hold     = 1'b1;
                    if (wait_cnt_q != '1)
                        wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    // Data returns this cycle; releasing the freeze lets EX take the forward.
                    state_d    = LDU_ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = LDU_ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign Ctrl_PcHold     = pc_hold & ~rst;
    assign Ctrl_IFIDHold   = ifid_hold & ~rst;
    assign Ctrl_IDEXFlush  = idex_flush & ~rst;
    assign Ctrl_PipeFreeze = pipe_freeze & ~rst;
    assign Ctrl_MemTimeout = timeout_q;
    assign Ctrl_State      = state_q;

`ifdef LD_USE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Perf_LuStallCnt <= '0;
            Perf_MemWaitCnt <= '0;
        end else begin
            if (idex_flush)
                Perf_LuStallCnt <= Perf_LuStallCnt + 32'd1;
            if (pipe_freeze)
                Perf_MemWaitCnt <= Perf_MemWaitCnt + 32'd1;
        end
    end
`endif

endmodule
